// File: rtl/shift_pass_sequencer.sv
// shift_pass_sequencer: multi-pass front end for a 64-bit, 5-bit-amount arithmetic-left
// barrel shifter. It splits shift amounts 0..63 into passes of at most 31 and tracks overflow.
`default_nettype none

module shift_pass_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_data,
    input  logic [5:0]  req_amt,
    output logic [63:0] sh_D_in,
    output logic [4:0]  sh_samt,
    input  logic [63:0] sh_D_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic        res_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] MAX_STEP = 6'd31;

    state_t      state;
    state_t      state_next;
    logic [63:0] acc;
    logic [5:0]  rem;
    logic        ovf;

    logic [4:0]  step;
    logic [5:0]  rem_next;
    logic        lost;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        acc <= req_data;
                        rem <= req_amt;
                        ovf <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc <= sh_D_out;
                    rem <= rem_next;
                    ovf <= ovf | lost;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        step       = (rem > MAX_STEP) ? MAX_STEP[4:0] : rem[4:0];
        rem_next   = rem - {1'b0, step};
        lost       = 1'b0;
        state_next = state;

        // Bits 62 down to 63-step are pushed out of the magnitude field this pass.
        for (int i = 0; i < 63; i++) begin
            if ((i + int'(step) >= 63) && (acc[i] != acc[63])) begin
                lost = 1'b1;
            end
        end

        case (state)
            IDLE:    if (req_valid)        state_next = SHIFT;
            SHIFT:   if (rem_next == 6'd0) state_next = DONE;
            DONE:    if (res_ready)        state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign res_data  = (state == DONE) ? acc : 64'd0;
    assign res_ovf   = (state == DONE) ? ovf : 1'b0;
    assign sh_D_in   = acc;
    assign sh_samt   = (state == SHIFT) ? step : 5'd0;

endmodule

`default_nettype wire

// File: tb/tb_shift_pass_sequencer.sv
// Self-checking bench for shift_pass_sequencer with a behavioural shifter model and
// a scoreboard of expected results computed as a single shift by the full amount.
`default_nettype none

module tb_shift_pass_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_data = '0;
    logic [5:0]  req_amt = '0;
    logic [63:0] sh_D_in;
    logic [4:0]  sh_samt;
    logic [63:0] sh_D_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
    logic        res_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        logic        ovf;
        logic [5:0]  amt;
        logic [63:0] src;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Shifter: sign held, magnitude shifted left, vacated low bits filled with ones.
    assign sh_D_out = {sh_D_in[63], (sh_D_in[62:0] << sh_samt) | ((63'd1 << sh_samt) - 63'd1)};

    shift_pass_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .sh_D_in   (sh_D_in),
        .sh_samt   (sh_samt),
        .sh_D_out  (sh_D_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf)
    );

    function automatic exp_t model(input logic [63:0] d, input logic [5:0] amt);
        exp_t        e;
        logic [62:0] mask;
        logic [62:0] top;
        mask   = (amt == 6'd0) ? 63'd0 : ((63'd1 << amt) - 63'd1);
        top    = (amt == 6'd0) ? 63'd0 : (d[62:0] >> (7'd63 - {1'b0, amt}));
        e.data = {d[63], (d[62:0] << amt) | mask};
        e.ovf  = |((top ^ {63{d[63]}}) & mask);
        e.amt  = amt;
        e.src  = d;
        return e;
    endfunction

    function automatic int passes_for(input logic [5:0] amt);
        return (amt == 6'd0) ? 1 : ((int'(amt) + 30) / 31);
    endfunction

    task automatic start_req(input logic [63:0] d, input logic [5:0] a);
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        sb.push_back(model(d, a));
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = $urandom();
        req_amt   = 6'($urandom());
    endtask

    // Observes passes until res_valid, checks the result, optionally stalls the consumer
    // (while offering a competing request), then completes the result handshake.
    task automatic finish_req(input int hold, input bit offer,
                              input logic [63:0] d2, input logic [5:0] a2);
        exp_t        e;
        int          passes;
        int          rem;
        int          step;
        logic [63:0] held_data;
        logic        held_ovf;
        e      = sb[0];
        rem    = int'(e.amt);
        passes = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid === 1'b1) break;
            step = (rem > 31) ? 31 : rem;
            rem  = rem - step;
            checks++;
            if (sh_samt !== 5'(step)) begin
                errors++;
                $display("FAIL pass_samt: pass %0d samt=%0d required %0d", passes, sh_samt, step);
            end
            if (passes == 0) begin
                checks++;
                if (sh_D_in !== e.src) begin
                    errors++;
                    $display("FAIL first_D_in: %h required %h", sh_D_in, e.src);
                end
            end
            passes++;
        end
        checks++;
        if (res_valid !== 1'b1 || passes != passes_for(e.amt)) begin
            errors++;
            $display("FAIL latency: passes=%0d res_valid=%b required %0d passes", passes, res_valid,
                     passes_for(e.amt));
        end
        void'(sb.pop_front());
        checks++;
        if (res_data !== e.data || res_ovf !== e.ovf) begin
            errors++;
            $display("FAIL result: data=%h ovf=%b required %h %b", res_data, res_ovf, e.data, e.ovf);
        end
        held_data = res_data;
        held_ovf  = res_ovf;
        if (offer) begin
            req_valid = 1'b1;
            req_data  = d2;
            req_amt   = a2;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== held_data || res_ovf !== held_ovf ||
                req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold: valid=%b data=%h ovf=%b ready=%b required 1 %h %b 0",
                         res_valid, res_data, res_ovf, req_ready, held_data, held_ovf);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_handshake: req_ready=%b res_valid=%b required 1 0", req_ready, res_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 64'd0 || res_ovf !== 1'b0 ||
            sh_samt !== 5'd0 || sh_D_in !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h ovf=%b samt=%0d din=%h required 1 0 0 0 0 0",
                     req_ready, res_valid, res_data, res_ovf, sh_samt, sh_D_in);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        start_req(64'h0000_0000_0000_0001, 6'd4);
        finish_req(0, 1'b0, '0, '0);
        start_req(64'h0000_0000_0000_0001, 6'd40);
        finish_req(0, 1'b0, '0, '0);
        start_req(64'h8000_0000_0000_0000, 6'd63);
        finish_req(0, 1'b0, '0, '0);
        start_req(64'h4000_0000_0000_0000, 6'd1);
        finish_req(0, 1'b0, '0, '0);
        start_req(64'h0000_0000_0000_1234, 6'd0);
        finish_req(0, 1'b0, '0, '0);
        start_req(64'h7FFF_FFFF_FFFF_FFFF, 6'd31);
        finish_req(1, 1'b0, '0, '0);
        start_req(64'hC000_0000_0000_0000, 6'd62);
        finish_req(0, 1'b0, '0, '0);
        start_req(64'h8000_0000_0000_0000, 6'd32);
        finish_req(0, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] d2;
        d2 = 64'h0123_4567_89AB_CDEF;
        start_req(64'h0000_0000_0000_0001, 6'd40);
        finish_req(5, 1'b1, d2, 6'd33);
        // Competing request is still asserted: it must be taken at the very next edge.
        sb.push_back(model(d2, 6'd33));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: req_ready=%b required 0", req_ready);
        end
        finish_req(0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_abort();
        start_req(64'h8000_0000_0000_0000, 6'd63);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || sh_samt !== 5'd0) begin
            errors++;
            $display("FAIL abort: ready=%b valid=%b samt=%0d required 1 0 0", req_ready, res_valid, sh_samt);
        end
        void'(sb.pop_back());
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: res_valid=%b required 0", res_valid);
            end
        end
        start_req(64'h0000_0000_0000_0001, 6'd4);
        finish_req(0, 1'b0, '0, '0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            start_req({$urandom(), $urandom()}, 6'($urandom_range(0, 63)));
            finish_req(int'($urandom_range(0, 2)), 1'b0, '0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
